fp_align_stage: RTL

//  Exponent-compare / mantissa-alignment front end for the FPU adder. Takes two
//  (exponent, 16-bit mantissa) operands, orders them by exponent, and drives the
//  16-bit right-rotating barrel shifter with the smaller mantissa and the

---
 rtl/fpu_pkg.sv | 19 +
 rtl/fp_align_mask_gen.sv | 37 +++
 rtl/fp_align_stage.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU constants and the packed alignment result carried between stages.
package fpu_pkg;

  // Mantissa width is tied to the 16-bit barrel shifter, which takes a 4-bit amount.
  localparam int MAN_W = 16;
  localparam int SH_W  = 4;

  // Mantissa-side alignment result. The exponent is parameterised per instance,
  // so it is registered beside this struct rather than inside it.
  typedef struct packed {
    logic [MAN_W-1:0] man_big;
    logic [MAN_W-1:0] sh_a;
    logic [SH_W-1:0]  sh_s;
    logic [MAN_W-1:0] keep_mask;
    logic             sticky;
    logic             swap;
  } align_res_t;

endpackage

// File: rtl/fp_align_mask_gen.sv
// Turns an exponent difference into shifter controls: rotate amount, a mask that
// clears wrapped-around bits, and the sticky OR of every bit shifted out.
module fp_align_mask_gen
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8
) (
  input  logic [EXP_W-1:0] diff,
  input  logic [MAN_W-1:0] man_small,
  output logic [SH_W-1:0]  sh_s,
  output logic [MAN_W-1:0] keep_mask,
  output logic             sticky
);

  logic             ovf;
  logic [SH_W-1:0]  amt;
  logic [MAN_W-1:0] lost_mask;

  // A difference of 16 or more shifts the whole mantissa out.
  assign ovf       = diff > EXP_W'(MAN_W - 1);
  assign amt       = diff[SH_W-1:0];
  // Low 'amt' bits: the ones that fall off the right end of a logical shift.
  assign lost_mask = ~({MAN_W{1'b1}} << amt);

  // Select in-range or fully-shifted-out controls.
  always_comb begin
    sh_s      = amt;
    keep_mask = {MAN_W{1'b1}} >> amt;
    sticky    = |(man_small & lost_mask);
    if (ovf) begin
      sh_s      = '0;
      keep_mask = '0;
      sticky    = |man_small;
    end
  end

endmodule

// File: rtl/fp_align_stage.sv
// Exponent compare and mantissa alignment front end for the FPU adder.
// Two registered stages with valid/ready flow control and no skid buffer.
module fp_align_stage
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8  // unsigned biased exponent, at least 5 bits
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] in_exp_a,
  input  logic [MAN_W-1:0] in_man_a,
  input  logic [EXP_W-1:0] in_exp_b,
  input  logic [MAN_W-1:0] in_man_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W-1:0] out_exp,
  output logic [MAN_W-1:0] out_man_big,
  output logic [MAN_W-1:0] out_sh_a,
  output logic [SH_W-1:0]  out_sh_s,
  output logic [MAN_W-1:0] out_keep_mask,
  output logic             out_sticky,
  output logic             out_swap
);

  // Pipeline control
  logic s1_valid_reg;
  logic s2_valid_reg;
  logic s1_load;
  logic s2_load;

  // Stage 1 state
  logic             s1_swap_reg;
  logic [EXP_W-1:0] s1_exp_big_reg;
  logic [EXP_W-1:0] s1_diff_reg;
  logic [MAN_W-1:0] s1_man_big_reg;
  logic [MAN_W-1:0] s1_man_small_reg;

  // Stage 1 combinational ordering
  logic             in_swap;
  logic [EXP_W-1:0] in_exp_big;
  logic [EXP_W-1:0] in_exp_small;
  logic [EXP_W-1:0] in_diff;

  // Stage 2 state
  logic [EXP_W-1:0] s2_exp_reg;
  align_res_t       s2_res_reg;
  align_res_t       s2_res_next;

  // Mask generator outputs
  logic [SH_W-1:0]  mg_sh_s;
  logic [MAN_W-1:0] mg_keep_mask;
  logic             mg_sticky;

  // Each stage advances when it is empty or its consumer takes its contents.
  assign s2_load  = !s2_valid_reg || out_ready;
  assign s1_load  = !s1_valid_reg || s2_load;
  assign in_ready = s1_load;

  // Equal exponents keep A as the big operand.
  assign in_swap      = in_exp_b > in_exp_a;
  assign in_exp_big   = in_swap ? in_exp_b : in_exp_a;
  assign in_exp_small = in_swap ? in_exp_a : in_exp_b;
  assign in_diff      = in_exp_big - in_exp_small;

  // Stage 1: capture ordered operands only on an input transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg     <= 1'b0;
      s1_swap_reg      <= 1'b0;
      s1_exp_big_reg   <= '0;
      s1_diff_reg      <= '0;
      s1_man_big_reg   <= '0;
      s1_man_small_reg <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_reg <= in_valid;
      end
      if (s1_load && in_valid) begin
        s1_swap_reg      <= in_swap;
        s1_exp_big_reg   <= in_exp_big;
        s1_diff_reg      <= in_diff;
        s1_man_big_reg   <= in_swap ? in_man_b : in_man_a;
        s1_man_small_reg <= in_swap ? in_man_a : in_man_b;
      end
    end
  end

  fp_align_mask_gen #(
    .EXP_W (EXP_W)
  ) u_mask_gen (
    .diff      (s1_diff_reg),
    .man_small (s1_man_small_reg),
    .sh_s      (mg_sh_s),
    .keep_mask (mg_keep_mask),
    .sticky    (mg_sticky)
  );

  // Assemble the stage-2 result from stage-1 state and the mask generator.
  always_comb begin
    s2_res_next           = '0;
    s2_res_next.man_big   = s1_man_big_reg;
    s2_res_next.sh_a      = s1_man_small_reg;
    s2_res_next.sh_s      = mg_sh_s;
    s2_res_next.keep_mask = mg_keep_mask;
    s2_res_next.sticky    = mg_sticky;
    s2_res_next.swap      = s1_swap_reg;
  end

  // Stage 2: hold results while stalled, load only when stage 1 has data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      s2_exp_reg   <= '0;
      s2_res_reg   <= '0;
    end else begin
      if (s2_load) begin
        s2_valid_reg <= s1_valid_reg;
      end
      if (s2_load && s1_valid_reg) begin
        s2_exp_reg <= s1_exp_big_reg;
        s2_res_reg <= s2_res_next;
      end
    end
  end

  assign out_valid     = s2_valid_reg;
  assign out_exp       = s2_exp_reg;
  assign out_man_big   = s2_res_reg.man_big;
  assign out_sh_a      = s2_res_reg.sh_a;
  assign out_sh_s      = s2_res_reg.sh_s;
  assign out_keep_mask = s2_res_reg.keep_mask;
  assign out_sticky    = s2_res_reg.sticky;
  assign out_swap      = s2_res_reg.swap;

endmodule
